// File: rtl/rec_arbiter.sv
// rec_arbiter: round-robin arbiter that shares one serial recurrent-data buffer
// among NREQ consumers. One buffer read is outstanding at a time; the returned
// ACK + 8-bit LSB-first stream is routed, one cycle late, to the granted consumer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transfer; grant the next pending requester, if any
// ST_WAIT   | BUF_REQ issued, waiting up to TIMEOUT cycles for BUF_ACK (bit0)
// ST_STREAM | receiving bits 1..7 from the buffer and routing them out
module rec_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  localparam int ID_W   = $clog2(NREQ),
  localparam int TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic [NREQ-1:0] REQ,
  output logic            BUF_REQ,
  input  logic            BUF_ACK,
  input  logic            BUF_DATA,
  output logic [NREQ-1:0] CL_ACK,
  output logic [NREQ-1:0] CL_DATA,
  output logic [ID_W-1:0] GRANT_ID,
  output logic            BUSY,
  output logic            TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] pending, pending_nxt, clr_mask;
  logic [ID_W-1:0] last_grant, last_grant_nxt, grant_id_nxt, arb_idx;
  logic            arb_found;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic            buf_req_nxt, timeout_err_nxt, route_en;
  logic [NREQ-1:0] cl_ack_nxt, cl_data_nxt;

  // Round-robin search: first pending index above the last grant, wrapping.
  always_comb begin : arb_search
    int              idx;
    logic [ID_W-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = last_grant;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Next-state, counters, pending update and routed outputs.
  always_comb begin
    state_nxt       = state;
    clr_mask        = '0;
    last_grant_nxt  = last_grant;
    grant_id_nxt    = GRANT_ID;
    to_cnt_nxt      = to_cnt;
    bit_cnt_nxt     = bit_cnt;
    buf_req_nxt     = 1'b0;
    timeout_err_nxt = 1'b0;
    route_en        = 1'b0;
    cl_ack_nxt      = '0;
    cl_data_nxt     = '0;

    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          grant_id_nxt = arb_idx;
          buf_req_nxt  = 1'b1;
          // Down-counter: terminal count 0 marks the last WAIT cycle allowed.
          to_cnt_nxt   = TO_W'(TIMEOUT - 1);
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (BUF_ACK) begin
          route_en    = 1'b1;
          bit_cnt_nxt = 3'd1;
          state_nxt   = ST_STREAM;
        end else if (to_cnt == '0) begin
          timeout_err_nxt    = 1'b1;
          clr_mask[GRANT_ID] = 1'b1;
          last_grant_nxt     = GRANT_ID;
          state_nxt          = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt - TO_W'(1);
        end
      end
      ST_STREAM: begin
        route_en = 1'b1;
        if (bit_cnt == 3'd7) begin
          clr_mask[GRANT_ID] = 1'b1;
          last_grant_nxt     = GRANT_ID;
          state_nxt          = ST_IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A new request in the completion cycle survives the clear.
    pending_nxt = (pending & ~clr_mask) | REQ;

    // ACK is only forwarded from WAIT; ACKs seen in STREAM are spurious.
    if (route_en) begin
      cl_data_nxt[GRANT_ID] = BUF_DATA;
      cl_ack_nxt[GRANT_ID]  = BUF_ACK && (state == ST_WAIT);
    end
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state       <= ST_IDLE;
      pending     <= '0;
      last_grant  <= ID_W'(NREQ - 1);
      GRANT_ID    <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      BUF_REQ     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      CL_ACK      <= '0;
      CL_DATA     <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      last_grant  <= last_grant_nxt;
      GRANT_ID    <= grant_id_nxt;
      to_cnt      <= to_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      BUF_REQ     <= buf_req_nxt;
      TIMEOUT_ERR <= timeout_err_nxt;
      CL_ACK      <= cl_ack_nxt;
      CL_DATA     <= cl_data_nxt;
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_rec_arbiter.sv
// tb_rec_arbiter: directed stimulus with a scoreboard; a buffer model answers
// BUF_REQ and a monitor reassembles each routed stream and compares it.
module tb_rec_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic [3:0] REQ = '0;
  logic       BUF_REQ;
  logic       BUF_ACK = 1'b0;
  logic       BUF_DATA = 1'b0;
  logic [3:0] CL_ACK, CL_DATA;
  logic [1:0] GRANT_ID;
  logic       BUSY, TIMEOUT_ERR;

  typedef struct {
    bit         is_to;
    int         id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    bit         ack;
    bit         spur;
    logic [7:0] d;
  } buf_t;

  exp_t exp_q[$];
  buf_t buf_q[$];
  int   breq_log[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_breq = 0;
  bit   breq_prev = 1'b0;
  int   spur_req = 0;
  int   spur_done = 0;

  rec_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .BUF_REQ(BUF_REQ), .BUF_ACK(BUF_ACK),
    .BUF_DATA(BUF_DATA), .CL_ACK(CL_ACK), .CL_DATA(CL_DATA), .GRANT_ID(GRANT_ID),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial forever #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_xfer(input int id, input logic [7:0] d, input bit spur);
    buf_q.push_back('{ack: 1'b1, spur: spur, d: d});
    exp_q.push_back('{is_to: 1'b0, id: id, data: d});
  endtask

  task automatic push_timeout(input int id);
    buf_q.push_back('{ack: 1'b0, spur: 1'b0, d: 8'h00});
    exp_q.push_back('{is_to: 1'b1, id: id, data: 8'h00});
  endtask

  task automatic pulse(input logic [3:0] v);
    @(posedge CLK); #1 REQ = v;
    @(posedge CLK); #1 REQ = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTB = 1'b0;
    #1 chk("reset_outputs", {BUF_REQ, CL_ACK, CL_DATA, GRANT_ID, BUSY, TIMEOUT_ERR}, 0);
    repeat (2) @(negedge CLK);
    RSTB = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(exp_q.size() == 0 && !BUSY) && n < budget);
    chk(name, n < budget, 1);
    repeat (12) @(negedge CLK);
  endtask

  task automatic wait_buf_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!BUF_ACK && n < 20);
    chk(name, BUF_ACK, 1);
  endtask

  // Buffer model: answers BUF_REQ one cycle later with ACK + LSB-first byte.
  buf_t ent;
  initial forever begin
    @(negedge CLK);
    if (spur_req != spur_done) begin
      spur_done = spur_req;
      @(posedge CLK); #1 BUF_ACK = 1'b1; BUF_DATA = 1'b1;
      @(posedge CLK); #1 BUF_ACK = 1'b0; BUF_DATA = 1'b0;
    end else if (RSTB && BUF_REQ && buf_q.size() > 0) begin
      ent = buf_q.pop_front();
      if (ent.ack) begin
        @(posedge CLK); #1 BUF_ACK = 1'b1; BUF_DATA = ent.d[0];
        for (int b = 1; b < 8; b++) begin
          @(posedge CLK); #1 BUF_ACK = ent.spur && (b == 4); BUF_DATA = ent.d[b];
        end
        @(posedge CLK); #1 BUF_ACK = 1'b0; BUF_DATA = 1'b0;
      end
    end
  end

  // BUF_REQ log, single-pulse check.
  initial forever begin
    @(negedge CLK);
    if (RSTB && BUF_REQ) begin
      chk("buf_req_single_pulse", breq_prev, 0);
      breq_log.push_back(cyc);
      last_breq = cyc;
    end
    breq_prev = RSTB && BUF_REQ;
  end

  // Scoreboard monitor.
  exp_t       e_mon;
  logic [7:0] got;
  logic [3:0] mask;
  int         id_mon, ack_at;
  bit         aborted, stray;
  initial forever begin
    @(negedge CLK);
    if (!RSTB) begin
      exp_q.delete();
      continue;
    end
    if (TIMEOUT_ERR) begin
      if (exp_q.size() == 0) chk("unexpected_timeout", 1, 0);
      else begin
        e_mon = exp_q.pop_front();
        chk("timeout_kind", e_mon.is_to, 1);
        chk("timeout_grant_id", GRANT_ID, e_mon.id);
        chk("timeout_latency", cyc - last_breq, TIMEOUT);
      end
    end
    if (|CL_ACK) begin
      ack_at = cyc;
      id_mon = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (CL_ACK[i]) id_mon = i;
      chk("cl_ack_onehot", $countones(CL_ACK), 1);
      mask = '0;
      mask[id_mon] = 1'b1;
      got = '0;
      got[0] = CL_DATA[id_mon];
      stray = (CL_DATA & ~mask) != 0;
      aborted = 1'b0;
      for (int b = 1; b < 8; b++) begin
        @(negedge CLK);
        if (!RSTB) begin
          aborted = 1'b1;
          break;
        end
        got[b] = CL_DATA[id_mon];
        stray |= (CL_ACK != 0) || ((CL_DATA & ~mask) != 0);
      end
      if (aborted) exp_q.delete();
      else if (exp_q.size() == 0) chk("unexpected_transfer", id_mon + 1, 0);
      else begin
        e_mon = exp_q.pop_front();
        chk("xfer_kind", e_mon.is_to, 0);
        chk("xfer_id", id_mon, e_mon.id);
        chk("xfer_data", got, e_mon.data);
        chk("xfer_ack_latency", ack_at - last_breq, 2);
        chk("xfer_stray_lines", stray, 0);
      end
    end else if (CL_DATA != 0) begin
      errors++;
      $display("FAIL cl_data_outside_stream actual=%0h required=0 (cycle %0d)", CL_DATA, cyc);
    end
  end

  logic [31:0] acc;
  initial begin
    do_reset();

    // Spurious ACK in IDLE is never routed and does not start a transfer.
    spur_req++;
    acc = '0;
    repeat (6) begin
      @(negedge CLK);
      acc |= {27'd0, CL_ACK, BUSY};
    end
    chk("spur_ack_ignored", acc, 0);

    // Single request to 2 (second pulse while pending is absorbed).
    breq_log.delete();
    push_xfer(2, 8'hA5, 1'b0);
    pulse(4'b0100);
    pulse(4'b0100);
    wait_idle("t1_done", 60);
    chk("t1_breq_count", breq_log.size(), 1);
    chk("t1_grant_id", GRANT_ID, 2);

    // All four at once after reset: grants 0,1,2,3 at 10-cycle spacing.
    do_reset();
    breq_log.delete();
    push_xfer(0, 8'h01, 1'b0);
    push_xfer(1, 8'h80, 1'b0);
    push_xfer(2, 8'hC3, 1'b0);
    push_xfer(3, 8'h7E, 1'b0);
    pulse(4'b1111);
    wait_idle("t2_done", 120);
    chk("t2_breq_count", breq_log.size(), 4);
    for (int k = 1; k < 4 && k < breq_log.size(); k++)
      chk("t2_breq_spacing", breq_log[k] - breq_log[k-1], 10);

    // Timeout on 1, then 3 served right after.
    breq_log.delete();
    push_timeout(1);
    push_xfer(3, 8'h96, 1'b0);
    pulse(4'b1010);
    wait_idle("t3_done", 100);
    chk("t3_breq_count", breq_log.size(), 2);
    if (breq_log.size() >= 2) chk("t3_breq_spacing", breq_log[1] - breq_log[0], 16);
    chk("t3_grant_id", GRANT_ID, 3);

    // Re-request from 0 in its final stream cycle; spurious ACK mid-stream.
    breq_log.delete();
    push_xfer(0, 8'h3C, 1'b1);
    push_xfer(0, 8'hE7, 1'b0);
    pulse(4'b0001);
    wait_buf_ack("t4_ack_seen");
    repeat (7) @(posedge CLK);
    #1 REQ = 4'b0001;
    @(posedge CLK); #1 REQ = '0;
    wait_idle("t4_done", 80);
    chk("t4_breq_count", breq_log.size(), 2);
    if (breq_log.size() >= 2) chk("t4_breq_spacing", breq_log[1] - breq_log[0], 10);

    // Reset at bit 4 of a stream to 1.
    push_xfer(1, 8'hFF, 1'b0);
    pulse(4'b0010);
    wait_buf_ack("t5_ack_seen");
    repeat (4) @(posedge CLK);
    #2 RSTB = 1'b0;
    #1 chk("t5_reset_outputs", {BUF_REQ, CL_ACK, CL_DATA, GRANT_ID, BUSY, TIMEOUT_ERR}, 0);
    repeat (2) @(negedge CLK);
    RSTB = 1'b1;
    acc = '0;
    repeat (12) begin
      @(negedge CLK);
      acc |= {22'd0, CL_ACK, CL_DATA, BUSY, BUF_REQ};
    end
    chk("t5_quiet_after_reset", acc, 0);
    buf_q.delete();
    breq_log.delete();
    push_xfer(0, 8'h69, 1'b0);
    push_xfer(2, 8'h0F, 1'b0);
    pulse(4'b0101);
    wait_idle("t5_fresh_done", 80);
    chk("t5_breq_count", breq_log.size(), 2);
    chk("t5_grant_id", GRANT_ID, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
